fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding request to instruction memory and
// fills the IF/ID register, with a skid buffer for stalls and a drain state for redirects.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pending_pc_q, pending_pc_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic        complete;
   logic [31:0] redirect_tgt;
   logic [31:0] pc_inc;

   assign redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign pc_inc       = pc_q + 32'd4;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = StFetch;
         StFetch: begin
            if (redirect && !complete) begin
               state_d = StDrain;
            end else if (!redirect && stall && complete) begin
               state_d = StHold;
            end
         end
         StHold:  if (redirect || !stall) state_d = StFetch;
         StDrain: if (complete) state_d = StFetch;
         default: state_d = StIdle;
      endcase
   end

   // Reset gates the request combinationally so an abandoned fetch never completes.
   always_comb begin
      imem_req   = rst_n && ((state_q == StFetch) || (state_q == StDrain));
      complete   = imem_req && imem_ready;
      fetch_busy = (imem_req && !imem_ready) || (state_q == StDrain);
      imem_addr  = pc_q;
   end

   always_comb begin
      pc_d          = pc_q;
      pending_pc_d  = pending_pc_q;
      skid_pc_d     = skid_pc_q;
      skid_instr_d  = skid_instr_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      if (redirect) begin
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
         skid_pc_d     = 32'd0;
         skid_instr_d  = NOP_INSTR;
         // A still-outstanding request must land before the new target can be issued.
         if (((state_q == StFetch) || (state_q == StDrain)) && !complete) begin
            pending_pc_d = redirect_tgt;
         end else begin
            pc_d = redirect_tgt;
         end
      end else begin
         unique case (state_q)
            StFetch: begin
               if (stall) begin
                  if (complete) begin
                     skid_pc_d    = pc_q;
                     skid_instr_d = imem_rdata;
                     pc_d         = pc_inc;
                  end
               end else if (complete) begin
                  if_id_pc_d    = pc_q;
                  if_id_instr_d = imem_rdata;
                  if_id_valid_d = 1'b1;
                  pc_d          = pc_inc;
               end else begin
                  if_id_valid_d = 1'b0;
                  if_id_instr_d = NOP_INSTR;
               end
            end
            StHold: begin
               if (!stall) begin
                  if_id_pc_d    = skid_pc_q;
                  if_id_instr_d = skid_instr_q;
                  if_id_valid_d = 1'b1;
               end
            end
            StDrain: begin
               if_id_valid_d = 1'b0;
               if_id_instr_d = NOP_INSTR;
               if (complete) pc_d = pending_pc_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         pending_pc_q  <= 32'd0;
         skid_pc_q     <= 32'd0;
         skid_instr_q  <= NOP_INSTR;
         if_id_pc_q    <= 32'd0;
         if_id_instr_q <= NOP_INSTR;
         if_id_valid_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         pending_pc_q  <= pending_pc_d;
         skid_pc_q     <= skid_pc_d;
         skid_instr_q  <= skid_instr_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with a scoreboard of instructions expected on IF/ID.
module tb_fetch_stage;

   localparam logic [31:0] ResetPc  = 32'h0000_0000;
   localparam logic [31:0] NopInstr = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        fetch_busy;

   int unsigned n_checks;
   int unsigned n_fail;
   logic [63:0] exp_q[$];

   fetch_stage #(
      .RESET_PC  (ResetPc),
      .NOP_INSTR (NopInstr)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid),
      .fetch_busy  (fetch_busy)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hA5C3_0000;
   endfunction

   assign imem_rdata = imem_ready ? instr_of(imem_addr) : 32'hDEAD_BEEF;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc);
      exp_q.push_back({pc, instr_of(pc)});
   endtask

   // Advance one cycle; a valid IF/ID after a non-stalled edge is a new instruction.
   task automatic cyc();
      logic        s;
      logic        r;
      logic [63:0] e;
      s = stall;
      r = rst_n;
      @(posedge clk);
      #1;
      if (r && !s && if_id_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_unexpected", {31'd0, if_id_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("sb_pc", if_id_pc, e[63:32]);
            check_eq("sb_instr", if_id_instr, e[31:0]);
         end
      end
   endtask

   task automatic drive(input logic rdy, input logic stl, input logic rdr, input logic [31:0] rpc);
      imem_ready  = rdy;
      stall       = stl;
      redirect    = rdr;
      redirect_pc = rpc;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_eq("rst_req_comb", {31'd0, imem_req}, 32'd0);
      cyc();
      cyc();
      check_eq("rst_if_id_pc", if_id_pc, 32'd0);
      check_eq("rst_if_id_instr", if_id_instr, NopInstr);
      check_eq("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
      check_eq("rst_busy", {31'd0, fetch_busy}, 32'd0);
      rst_n = 1'b1;
      #1;
      check_eq("idle_no_req", {31'd0, imem_req}, 32'd0);
      cyc();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0);

      // Zero-wait streaming
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("first_req", {31'd0, imem_req}, 32'd1);
      check_eq("first_addr", imem_addr, ResetPc);
      push(32'h0);
      cyc();
      check_eq("stream_v0", {31'd0, if_id_valid}, 32'd1);
      push(32'h4);
      cyc();
      check_eq("stream_v1", {31'd0, if_id_valid}, 32'd1);
      push(32'h8);
      cyc();
      check_eq("stream_v2", {31'd0, if_id_valid}, 32'd1);
      check_eq("stream_pc2", if_id_pc, 32'h8);

      // Wait states on 0x8
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      push(32'h0);
      cyc();
      push(32'h4);
      cyc();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'd0);
         check_eq("wait_addr", imem_addr, 32'h8);
         check_eq("wait_busy", {31'd0, fetch_busy}, 32'd1);
         cyc();
         check_eq("wait_bubble", {31'd0, if_id_valid}, 32'd0);
         check_eq("wait_bubble_nop", if_id_instr, NopInstr);
      end
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("wait_done_busy", {31'd0, fetch_busy}, 32'd0);
      push(32'h8);
      cyc();
      push(32'hC);
      cyc();

      // Stall while 0x10 completes
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      check_eq("stall_addr", imem_addr, 32'h10);
      cyc();
      for (int i = 0; i < 2; i++) begin
         check_eq("hold_no_req", {31'd0, imem_req}, 32'd0);
         check_eq("hold_if_id_pc", if_id_pc, 32'hC);
         check_eq("hold_if_id_valid", {31'd0, if_id_valid}, 32'd1);
         cyc();
      end
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      push(32'h10);
      cyc();
      check_eq("unstall_pc", if_id_pc, 32'h10);
      check_eq("unstall_req", {31'd0, imem_req}, 32'd1);
      check_eq("unstall_addr", imem_addr, 32'h14);
      push(32'h14);
      cyc();
      push(32'h18);
      cyc();
      push(32'h1C);
      cyc();

      // Redirect while 0x20 outstanding
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_eq("pre_drain_addr", imem_addr, 32'h20);
      cyc();
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0103);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check_eq("drain_busy", {31'd0, fetch_busy}, 32'd1);
      check_eq("drain_req", {31'd0, imem_req}, 32'd1);
      check_eq("drain_addr", imem_addr, 32'h20);
      check_eq("drain_flush", {31'd0, if_id_valid}, 32'd0);
      cyc();
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("drain_addr_ready", imem_addr, 32'h20);
      cyc();
      check_eq("drain_done_valid", {31'd0, if_id_valid}, 32'd0);
      check_eq("redir_addr", imem_addr, 32'h100);

      // Redirect together with stall in HOLD
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      cyc();
      check_eq("hold2_no_req", {31'd0, imem_req}, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
      cyc();
      check_eq("hold_redir_valid", {31'd0, if_id_valid}, 32'd0);
      check_eq("hold_redir_req", {31'd0, imem_req}, 32'd1);
      check_eq("hold_redir_addr", imem_addr, 32'h40);
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      push(32'h40);
      cyc();

      // Redirect with completion to the top of the address space, then wrap
      drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      cyc();
      check_eq("wrap_flush", {31'd0, if_id_valid}, 32'd0);
      check_eq("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      push(32'hFFFF_FFFC);
      cyc();
      check_eq("wrap_addr_zero", imem_addr, 32'h0);
      push(32'h0);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
      check_eq("mid_wait_busy", {31'd0, fetch_busy}, 32'd1);

      // Reset mid-wait, then restart
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("restart_req", {31'd0, imem_req}, 32'd1);
      check_eq("restart_addr", imem_addr, ResetPc);
      push(ResetPc);
      cyc();
      check_eq("restart_valid", {31'd0, if_id_valid}, 32'd1);
      check_eq("sb_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
